// File: rtl/stage_ex_muldiv_pkg.sv
// Shared op codes, FSM states and iteration count for the EX-stage mul/div sequencer.
package stage_ex_muldiv_pkg;

  localparam int unsigned ITER = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_e;

endpackage

// File: rtl/stage_ex_muldiv_step.sv
// One mul/div iteration: shift-add (multiply) or compare-subtract-shift (restoring divide).
module stage_ex_muldiv_step
  import stage_ex_muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  op_e               op_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opnd_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] diff;
  logic            ge;

  always_comb begin
    // Multiply: acc = {partial product, unconsumed multiplier}, shifted right each step.
    sum   = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    // Divide: acc = {remainder, dividend/quotient}, shifted left each step.
    trial = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-1]};
    ge    = trial >= {1'b0, opnd_i};
    diff  = trial[XLEN-1:0] - opnd_i;
    if (op_i inside {OP_DIV, OP_DIVU}) begin
      acc_o = {(ge ? diff : trial[XLEN-1:0]), acc_i[XLEN-2:0], ge};
    end else begin
      acc_o = {sum, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/stage_ex_muldiv_ctrl.sv
// EX-stage multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// Define MULDIV_EARLY_EXIT_EN for data-dependent early termination.
module stage_ex_muldiv_ctrl
  import stage_ex_muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ITER = stage_ex_muldiv_pkg::ITER
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_ex,
  input  logic [1:0]      op_ex,
  input  logic [XLEN-1:0] a_ex,
  input  logic [XLEN-1:0] b_ex,
  input  logic            flush_ex,
  input  logic            wr_hi,
  input  logic            wr_lo,
  input  logic [XLEN-1:0] wdata,
  output logic            stall_ex,
  output logic            done_ex,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int unsigned CW = $clog2(ITER);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d, acc_step, prod;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [XLEN-1:0]   a_abs, b_abs, quo, rem;
  logic              neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic              done_q, done_d;
  logic              sgn_op;

  stage_ex_muldiv_step #(.XLEN(XLEN)) u_step (
    .op_i  (op_q),
    .acc_i (acc_q),
    .opnd_i(opnd_q),
    .acc_o (acc_step)
  );

  always_comb begin
    sgn_op = ~op_ex[0];
    a_abs  = (sgn_op && a_ex[XLEN-1]) ? -a_ex : a_ex;
    b_abs  = (sgn_op && b_ex[XLEN-1]) ? -b_ex : b_ex;
    prod   = neg_quo_q ? -acc_q : acc_q;
    quo    = neg_quo_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem    = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_ex && !flush_ex) begin
          op_d      = op_e'(op_ex);
          cnt_d     = '0;
          neg_quo_d = sgn_op & (a_ex[XLEN-1] ^ b_ex[XLEN-1]);
          neg_rem_d = sgn_op & a_ex[XLEN-1];
          state_d   = CALC;
          if (op_ex[1]) begin
            opnd_d = b_abs;
            acc_d  = {{XLEN{1'b0}}, a_abs};
          end else begin
            opnd_d = a_abs;
            acc_d  = {{XLEN{1'b0}}, b_abs};
          end
`ifdef MULDIV_EARLY_EXIT_EN
          // A zero divisor yields quotient all-ones and remainder = dividend without iterating.
          if (op_ex[1] && b_ex == '0) begin
            acc_d   = {a_abs, {XLEN{1'b1}}};
            state_d = FIX;
          end
`endif
        end
      end
      CALC: begin
        if (flush_ex) begin
          state_d = IDLE;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(ITER - 1)) state_d = FIX;
`ifdef MULDIV_EARLY_EXIT_EN
          // Remaining multiplier bits all zero: the rest of the steps are pure right shifts.
          if ((op_q inside {OP_MULT, OP_MULTU}) &&
              ((acc_q[XLEN-1:0] & ({XLEN{1'b1}} >> cnt_q)) == '0)) begin
            acc_d   = acc_q >> (XLEN - cnt_q);
            state_d = FIX;
          end
`endif
        end
      end
      FIX: begin
        if (flush_ex) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
          if (op_q inside {OP_MULT, OP_MULTU}) begin
            {hi_d, lo_d} = prod;
          end else begin
            hi_d = rem;
            lo_d = quo;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_q == IDLE || state_q == DONE) begin
      if (wr_hi) hi_d = wdata;
      if (wr_lo) lo_d = wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= OP_MULT;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      done_q    <= done_d;
    end
  end

  assign stall_ex = (state_q == IDLE && start_ex && !flush_ex) ||
                    state_q == CALC || state_q == FIX;
  assign done_ex  = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
